// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that multiplexes N_REQ packet
// requesters onto a single FIFO write port. A grant is held for one packet
// or MAX_BURST beats, whichever ends first, then the port goes back to IDLE
// for one cycle before the next grant is made.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 3,
  parameter int D_WIDTH   = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       w_clk,
  input  logic                       w_rstn,
  input  logic                       arb_en,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       full,
  output logic                       w_inc,
  output logic [D_WIDTH-1:0]         w_data,
  output logic [N_REQ-1:0]           gnt_onehot,
  output logic                       busy
);

  localparam int          IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int          CNT_W = $clog2(MAX_BURST) + 1;
  localparam int unsigned NR_U  = N_REQ;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]         state;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   last_gnt;
  logic [CNT_W-1:0]   beat_cnt;
  // Low for the first edge after reset release so no grant can be taken
  // on that edge.
  logic               armed;

  logic               in_xfer;
  logic               sel_valid;
  logic               sel_last;
  logic [D_WIDTH-1:0] sel_data;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   cand;
  logic               rr_found;
  logic               grant_ok;
  logic               burst_end;

  assign in_xfer = (state == XFER);

  // Route the granted requester's valid/last/data onto internal selects.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NR_U; i++) begin
      if (IDX_W'(i) == gnt_idx) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  // Round-robin search: first valid requester after last_gnt, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NR_U; k++) begin
      cand = IDX_W'((32'(last_gnt) + k) % NR_U);
      if (!rr_found && req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign grant_ok  = (state == IDLE) && armed && arb_en && rr_found;
  assign w_inc     = in_xfer && sel_valid && !full;
  assign burst_end = w_inc && (sel_last || (beat_cnt == CNT_W'(MAX_BURST - 1)));
  assign w_data    = in_xfer ? sel_data : '0;
  assign busy      = in_xfer;

  // Per-requester handshake and ownership flags for the current grant.
  always_comb begin
    req_ready  = '0;
    gnt_onehot = '0;
    for (int unsigned i = 0; i < NR_U; i++) begin
      if (in_xfer && (IDX_W'(i) == gnt_idx)) begin
        gnt_onehot[i] = 1'b1;
        req_ready[i]  = !full;
      end
    end
  end

  // Grant FSM, beat counter and round-robin pointer.
  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      beat_cnt <= '0;
      last_gnt <= IDX_W'(N_REQ - 1);
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            state    <= XFER;
            gnt_idx  <= rr_idx;
            beat_cnt <= '0;
          end
        end
        XFER: begin
          if (w_inc) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
          if (burst_end) begin
            state    <= IDLE;
            last_gnt <= gnt_idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters sharing the FIFO write port.
REQ-002 Parameter D_WIDTH, default 8: data word width.
REQ-003 Parameter MAX_BURST, default 4: maximum beats per grant, at least 1.
REQ-004 The block SHALL provide these ports:
- w_clk  in  1  write-domain clock.
- w_rstn  in  1  reset: asynchronous, active-low.
- arb_en  in  1  permits new grants when high.
- req_valid  in  N_REQ  per-requester beat valid.
- req_data  in  N_REQ*D_WIDTH  requester i data on bits [i*D_WIDTH +: D_WIDTH].
- req_last  in  N_REQ  per-requester last beat of packet.
- req_ready  out  N_REQ  per-requester beat accepted.
- full  in  1  FIFO full flag, from the write-side pointer logic.
- w_inc  out  1  FIFO write strobe.
- w_data  out  D_WIDTH  FIFO write data.
- gnt_onehot  out  N_REQ  current owner of the write port.
- busy  out  1  high while a grant is held.

Function
REQ-005 The block SHALL implement an FSM with two states: IDLE and XFER.
REQ-006 In IDLE with arb_en=1 and any req_valid high, the block SHALL select the first valid requester in round-robin order starting at last_gnt+1 (modulo N_REQ).
- It SHALL register the winner in gnt_idx and enter XFER on the next edge.
- Arbitration latency is exactly 1 cycle.
REQ-007 In IDLE with arb_en=0 or no req_valid, the block SHALL remain in IDLE, and gnt_onehot SHALL be 0.
REQ-008 In XFER the following SHALL hold combinationally:
- req_ready[gnt_idx] = !full.
- All other req_ready bits = 0.
- w_inc = req_valid[gnt_idx] && !full.
- w_data = req_data slice of gnt_idx.
REQ-009 w_inc SHALL never be high while full=1, and SHALL never be high outside XFER.
REQ-010 A beat is accepted when w_inc=1. On acceptance beat_cnt SHALL increment.
- beat_cnt is a counter of width clog2(MAX_BURST)+1.
- beat_cnt is cleared on entry to XFER.
REQ-011 XFER SHALL return to IDLE on the edge after an accepted beat with req_last=1 or beat_cnt==MAX_BURST-1.
- On that edge last_gnt SHALL be updated to gnt_idx.
REQ-012 While in XFER, if req_valid[gnt_idx]=0 or full=1, the block SHALL hold XFER, gnt_idx and beat_cnt unchanged. There is no timeout.
REQ-013 Deasserting arb_en during XFER SHALL NOT abort the burst. It only blocks the next grant.
REQ-014 On an XFER-to-IDLE edge, the block SHALL spend one cycle in IDLE before any new grant. Back-to-back bursts are therefore separated by one idle cycle.
REQ-015 busy SHALL be high in XFER. gnt_onehot SHALL be the one-hot form of gnt_idx in XFER, and 0 otherwise.
REQ-016 Requester inputs changing while not granted SHALL have no effect on w_inc or w_data.

Reset
REQ-017 Assertion of w_rstn=0 SHALL immediately force the following, including mid-burst:
- state=IDLE, gnt_idx=0, beat_cnt=0, last_gnt=N_REQ-1.
- Consequently w_inc=0, req_ready=0, gnt_onehot=0, busy=0.
REQ-018 After reset release, requester 0 SHALL hold first priority. The first grant SHALL occur no earlier than the second rising edge after release.

Verification
REQ-019 All valid with 1-beat packets (req_last=1), full=0: grants SHALL follow 0,1,2,0; w_inc SHALL pulse every second cycle with w_data matching each owner's data.
REQ-020 Requester 1 sends 6 beats with req_last on beat 6, MAX_BURST=4: the first grant SHALL carry 4 beats. Requester 1 re-arbitrates in round-robin order, and the remaining 2 beats SHALL follow in a later grant.
REQ-021 full=1 for 3 cycles mid-burst: w_inc=0 and req_ready=0 during those cycles; beat_cnt SHALL hold; no data SHALL be lost or duplicated after full drops.
REQ-022 w_rstn pulsed low during beat 2 of a burst: outputs SHALL reach 0 asynchronously; after release with req_valid=3'b110 the first grant SHALL go to requester 1.
REQ-023 arb_en dropped during a 3-beat burst: the burst SHALL complete all 3 beats; no further grant SHALL occur until arb_en=1, and the grant SHALL follow 1 cycle after arb_en rises.
